// File: rtl/trng_health_monitor_if.sv
// trng_health_monitor_if
//   Bundles the bit-stream handshake and status outputs of trng_health_monitor.
//   master: the upstream debiaser / software side (drives clear, bit_in, bit_valid).
//   slave : the health monitor (drives forwarded bit, health and statistics).
//
//   clear         : software clear, restarts startup testing
//   bit_in        : debiased bit, qualified by bit_valid
//   bit_valid     : single-cycle strobe, no back-pressure
//   bit_out       : forwarded bit, qualified by bit_out_valid
//   bit_out_valid : single-cycle strobe, no back-pressure
//   healthy       : high only in state OK
//   rct_fail      : sticky repetition count test failure
//   apt_fail      : sticky adaptive proportion test failure
//   alarm         : rct_fail | apt_fail
//   state         : 00 STARTUP, 01 OK, 10 FAIL
//   max_run       : longest identical-bit run since reset/clear (saturating)
//   bits_tested   : valid bits consumed since reset/clear (saturating)
interface trng_health_monitor_if;
    logic        clear;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_out;
    logic        bit_out_valid;
    logic        healthy;
    logic        rct_fail;
    logic        apt_fail;
    logic        alarm;
    logic [1:0]  state;
    logic [15:0] max_run;
    logic [31:0] bits_tested;

    modport master (
        output clear, bit_in, bit_valid,
        input  bit_out, bit_out_valid, healthy, rct_fail, apt_fail, alarm,
               state, max_run, bits_tested
    );

    modport slave (
        input  clear, bit_in, bit_valid,
        output bit_out, bit_out_valid, healthy, rct_fail, apt_fail, alarm,
               state, max_run, bits_tested
    );
endinterface

// File: rtl/trng_health_monitor.sv
// trng_health_monitor
//   Online health test for a debiased TRNG bit stream. Runs a Repetition Count
//   Test and an Adaptive Proportion Test on every valid bit, forwards bits only
//   while the source is healthy, and latches sticky failure flags.
//
//   Ports:
//     clk : system clock
//     rst : synchronous active-high reset (priority over clear)
//     hm  : trng_health_monitor_if.slave (bit stream in/out, health, statistics)
//
//   Handshake: bit_valid and bit_out_valid are single-cycle strobes with no
//   ready/back-pressure; a bit is consumed on every clock edge where bit_valid
//   is high and clear/rst are low, and its effects appear on the next cycle.
module trng_health_monitor #(
    parameter int RCT_CUTOFF   = 32,
    parameter int APT_WINDOW   = 1024,
    parameter int APT_CUTOFF   = 589,
    parameter int STARTUP_BITS = 1024
) (
    input logic                  clk,
    input logic                  rst,
    trng_health_monitor_if.slave hm
);

    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam int AW = $clog2(APT_WINDOW + 1);
    localparam int SW = $clog2(STARTUP_BITS + 1);

    localparam logic [RW-1:0] RCT_CUT = RW'(RCT_CUTOFF);
    localparam logic [AW-1:0] APT_WIN = AW'(APT_WINDOW);
    localparam logic [AW-1:0] APT_CUT = AW'(APT_CUTOFF);
    localparam logic [SW-1:0] SU_BITS = SW'(STARTUP_BITS);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'b00,
        ST_OK      = 2'b01,
        ST_FAIL    = 2'b10
    } state_e;

    state_e      state_q;
    logic        have_q, have_d;      // a previous bit exists for the RCT
    logic        last_q, last_d;
    logic [RW-1:0] run_q, run_d;
    logic        apt_open_q, apt_open_d; // an APT window is in progress
    logic        ref_q, ref_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] su_q, su_inc;
    logic        rct_q, apt_q, alarm_q, healthy_q;
    logic [15:0] max_run_q, max_run_d;
    logic [31:0] bits_q, bits_d;
    logic        bit_out_q, bov_q;
    logic        rct_hit, apt_hit, fail_now;
    logic [15:0] run_ext;

    always_comb begin
        have_d     = 1'b1;
        last_d     = hm.bit_in;
        run_d      = RW'(1);
        apt_open_d = apt_open_q;
        ref_d      = ref_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        su_inc     = su_q + SW'(1);
        max_run_d  = max_run_q;
        bits_d     = (bits_q == 32'hFFFF_FFFF) ? bits_q : bits_q + 32'd1;

        // RCT: extend the run on a repeat, saturating at the cutoff.
        if (have_q && (hm.bit_in == last_q)) begin
            run_d = (run_q >= RCT_CUT) ? RCT_CUT : run_q + RW'(1);
        end
        rct_hit = (run_d >= RCT_CUT);

        run_ext = 16'(run_d);
        if (run_ext > max_run_q) begin
            max_run_d = run_ext;
        end

        // APT: the first bit of a window is the reference and counts as a match.
        if (!apt_open_q) begin
            ref_d = hm.bit_in;
            idx_d = AW'(1);
            cnt_d = AW'(1);
        end else begin
            idx_d = idx_q + AW'(1);
            cnt_d = cnt_q + AW'(hm.bit_in == ref_q);
        end
        apt_hit    = (cnt_d >= APT_CUT);
        apt_open_d = (idx_d != APT_WIN);

        fail_now = rct_hit | apt_hit;
    end

    always_ff @(posedge clk) begin
        if (rst || hm.clear) begin
            state_q    <= ST_STARTUP;
            have_q     <= 1'b0;
            last_q     <= 1'b0;
            run_q      <= '0;
            apt_open_q <= 1'b0;
            ref_q      <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            su_q       <= '0;
            rct_q      <= 1'b0;
            apt_q      <= 1'b0;
            alarm_q    <= 1'b0;
            healthy_q  <= 1'b0;
            max_run_q  <= '0;
            bits_q     <= '0;
            bit_out_q  <= 1'b0;
            bov_q      <= 1'b0;
        end else begin
            bov_q <= 1'b0;
            if (hm.bit_valid) begin
                have_q     <= have_d;
                last_q     <= last_d;
                run_q      <= run_d;
                apt_open_q <= apt_open_d;
                ref_q      <= ref_d;
                idx_q      <= idx_d;
                cnt_q      <= cnt_d;
                max_run_q  <= max_run_d;
                bits_q     <= bits_d;
                rct_q      <= rct_q | rct_hit;
                apt_q      <= apt_q | apt_hit;
                alarm_q    <= rct_q | apt_q | fail_now;

                case (state_q)
                    ST_STARTUP: begin
                        if (fail_now) begin
                            state_q   <= ST_FAIL;
                            healthy_q <= 1'b0;
                        end else begin
                            su_q <= su_inc;
                            // The completing bit itself is not forwarded.
                            if (su_inc == SU_BITS) begin
                                state_q   <= ST_OK;
                                healthy_q <= 1'b1;
                            end
                        end
                    end
                    ST_OK: begin
                        if (fail_now) begin
                            state_q   <= ST_FAIL;
                            healthy_q <= 1'b0;
                        end else begin
                            bov_q     <= 1'b1;
                            bit_out_q <= hm.bit_in;
                        end
                    end
                    ST_FAIL: begin
                        healthy_q <= 1'b0;
                    end
                    default: begin
                        state_q   <= ST_FAIL;
                        healthy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign hm.bit_out       = bit_out_q;
    assign hm.bit_out_valid = bov_q;
    assign hm.healthy       = healthy_q;
    assign hm.rct_fail      = rct_q;
    assign hm.apt_fail      = apt_q;
    assign hm.alarm         = alarm_q;
    assign hm.state         = state_q;
    assign hm.max_run       = max_run_q;
    assign hm.bits_tested   = bits_q;

endmodule

// File: tb/tb_trng_health_monitor.sv
module tb_trng_health_monitor;
    localparam int RCT  = 32;
    localparam int WIN  = 1024;
    localparam int APTC = 589;
    localparam int SU   = 1024;
    localparam int W    = 55;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_s = 1'b1;
    always #5 clk = ~clk;

    trng_health_monitor_if m_if();
    trng_health_monitor_if s_if();

    trng_health_monitor #(
        .RCT_CUTOFF(RCT), .APT_WINDOW(WIN), .APT_CUTOFF(APTC), .STARTUP_BITS(SU)
    ) u_dut (
        .clk(clk), .rst(rst), .hm(m_if)
    );

    trng_health_monitor #(
        .RCT_CUTOFF(4), .APT_WINDOW(16), .APT_CUTOFF(14), .STARTUP_BITS(16)
    ) u_sat (
        .clk(clk), .rst(rst_s), .hm(s_if)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    bit     tail_q[$];   // trailing run of identical bits, capped at RCT
    bit     win_q[$];    // bits of the current APT window
    int     m_state;     // 0 STARTUP, 1 OK, 2 FAIL
    int     m_started;
    int     m_max;
    longint m_tested;
    bit     m_rct, m_apt, m_fwd;

    function automatic void model_reset();
        tail_q.delete();
        win_q.delete();
        m_state = 0; m_started = 0; m_max = 0; m_tested = 0;
        m_rct = 0; m_apt = 0; m_fwd = 0;
    endfunction

    function automatic void model_bit(input bit b);
        int run, cnt;
        bit fail;
        if (tail_q.size() > 0 && tail_q[0] != b) tail_q.delete();
        tail_q.push_back(b);
        if (tail_q.size() > RCT) void'(tail_q.pop_front());
        run = tail_q.size();
        if (win_q.size() == WIN) win_q.delete();
        win_q.push_back(b);
        cnt = 0;
        foreach (win_q[k]) if (win_q[k] == win_q[0]) cnt++;
        fail = (run >= RCT) || (cnt >= APTC);
        if (run > m_max) m_max = run;
        if (m_tested < 64'hFFFF_FFFF) m_tested++;
        m_fwd = (m_state == 1) && !fail;
        if (run >= RCT) m_rct = 1;
        if (cnt >= APTC) m_apt = 1;
        if (fail) m_state = 2;
        else if (m_state == 0) begin
            m_started++;
            if (m_started == SU) m_state = 1;
        end
    endfunction

    function automatic logic [W-1:0] exp_snap();
        return {m_fwd, 2'(m_state), (m_state == 1), m_rct, m_apt, (m_rct | m_apt),
                16'(m_max), 32'(m_tested)};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    bit           fwd_q[$];
    int           exp_fwd_total = 0;
    int           seen_fwd = 0;
    logic         mon_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(posedge clk) mon_pend <= m_if.bit_valid | m_if.clear | rst;

    always @(negedge clk) begin
        logic [W-1:0] act, e;
        bit           eb;
        if (m_if.bit_out_valid === 1'b1) begin
            seen_fwd++;
            checks++;
            if (fwd_q.size() == 0) begin
                errors++;
                $display("FAIL fwd_unexpected: got bit_out_valid=1 expected 0");
            end else begin
                eb = fwd_q.pop_front();
                if (m_if.bit_out !== eb) begin
                    errors++;
                    $display("FAIL fwd_bit: got %b expected %b", m_if.bit_out, eb);
                end
            end
        end
        if (mon_pend) begin
            act = {m_if.bit_out_valid, m_if.state, m_if.healthy, m_if.rct_fail, m_if.apt_fail,
                   m_if.alarm, m_if.max_run, m_if.bits_tested};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL status_underflow: got %h expected nothing queued", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL status: got bov=%b st=%0d h=%b rct=%b apt=%b al=%b max=%0d n=%0d expected bov=%b st=%0d h=%b rct=%b apt=%b al=%b max=%0d n=%0d",
                             act[54], act[53:52], act[51], act[50], act[49], act[48], act[47:32], act[31:0],
                             e[54], e[53:52], e[51], e[50], e[49], e[48], e[47:32], e[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input bit b, input bit clr, input bit rs);
        m_if.bit_valid = v;
        m_if.bit_in    = b;
        m_if.clear     = clr;
        rst            = rs;
        @(posedge clk);
        if (rs || clr) model_reset();
        else if (v) model_bit(b);
        if (rs || clr || v) begin
            exp_q.push_back(exp_snap());
            if (m_fwd && v && !rs && !clr) begin
                fwd_q.push_back(b);
                exp_fwd_total++;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0);
    endtask

    task automatic send_alt(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, i[0], 0, 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
    endtask

    task automatic sdrive(input bit v, input bit b, input bit rs);
        s_if.bit_valid = v;
        s_if.bit_in    = b;
        s_if.clear     = 1'b0;
        rst_s          = rs;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int f0;
        m_if.bit_valid = 0; m_if.bit_in = 0; m_if.clear = 0;
        s_if.bit_valid = 0; s_if.bit_in = 0; s_if.clear = 0;
        model_reset();

        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        check("reset_state", 32'(m_if.state), 0);
        check("reset_bits_tested", m_if.bits_tested, 0);

        // Startup with alternating bits.
        send_alt(1024);
        check("startup_state", 32'(m_if.state), 1);
        check("startup_healthy", 32'(m_if.healthy), 1);
        check("startup_bits_tested", m_if.bits_tested, 1024);
        check("startup_max_run", 32'(m_if.max_run), 1);
        idle(1);
        check("startup_no_fwd", seen_fwd, 0);

        // RCT boundary: a 0 to break the run, then 31 ones, then the 32nd.
        f0 = seen_fwd;
        drive(1, 0, 0, 0);
        for (int i = 0; i < 31; i++) drive(1, 1, 0, 0);
        idle(1);
        check("rct_31_no_fail", 32'(m_if.rct_fail), 0);
        check("rct_31_fwd", seen_fwd - f0, 32);
        drive(1, 1, 0, 0);
        check("rct_32_fail", 32'(m_if.rct_fail), 1);
        check("rct_32_alarm", 32'(m_if.alarm), 1);
        check("rct_32_state", 32'(m_if.state), 2);
        check("rct_32_max_run", 32'(m_if.max_run), 32);
        idle(1);
        f0 = seen_fwd;
        for (int i = 0; i < 8; i++) drive(1, 1'($urandom_range(0, 1)), 0, 0);
        idle(1);
        check("fail_no_fwd", seen_fwd - f0, 0);

        // Clear coincident with a valid bit while in FAIL.
        drive(1, 1, 1, 0);
        check("clear_bits_tested", m_if.bits_tested, 0);
        check("clear_state", 32'(m_if.state), 0);
        check("clear_alarm", 32'(m_if.alarm), 0);

        // APT: fresh window of repeating 1,1,0.
        send_alt(1024);
        for (int i = 0; i < 900; i++) begin
            drive(1, (i % 3) != 2, 0, 0);
            if (i == 881) check("apt_882_no_fail", 32'(m_if.apt_fail), 0);
            if (i == 882) begin
                check("apt_883_fail", 32'(m_if.apt_fail), 1);
                check("apt_883_rct", 32'(m_if.rct_fail), 0);
            end
        end

        // Control: alternating bits over three windows never fail.
        drive(0, 0, 1, 0);
        send_alt(1024);
        send_alt(3 * 1024);
        check("apt_control_no_fail", 32'(m_if.apt_fail), 0);
        check("apt_control_state", 32'(m_if.state), 1);

        // Reset mid-window in OK coincident with a valid bit.
        send_alt(100);
        drive(1, 1, 0, 1);
        check("rst_mid_bits_tested", m_if.bits_tested, 0);
        check("rst_mid_state", 32'(m_if.state), 0);
        send_alt(1023);
        check("rst_1023_state", 32'(m_if.state), 0);
        drive(1, 1, 0, 0);
        check("rst_1024_state", 32'(m_if.state), 1);

        // Random runs with occasional clears, checked by the scoreboard.
        for (int r = 0; r < 60; r++) begin
            bit v;
            int len;
            v = r[0];
            len = $urandom_range(1, 34);
            for (int i = 0; i < len; i++) begin
                drive(1, v, 0, 0);
                if ($urandom_range(0, 5) == 0) idle(1);
            end
            if ($urandom_range(0, 14) == 0) drive(1, 0, 1, 0);
        end
        idle(3);

        // Saturation with RCT cutoff 4.
        sdrive(0, 0, 1);
        sdrive(0, 0, 1);
        for (int i = 1; i <= 10; i++) begin
            sdrive(1, 0, 0);
            if (i == 3) begin
                check("sat_3_rct", 32'(s_if.rct_fail), 0);
                check("sat_3_state", 32'(s_if.state), 0);
            end
            if (i == 4) begin
                check("sat_4_rct", 32'(s_if.rct_fail), 1);
                check("sat_4_state", 32'(s_if.state), 2);
                check("sat_4_max_run", 32'(s_if.max_run), 4);
            end
        end
        check("sat_10_max_run", 32'(s_if.max_run), 4);
        check("sat_10_bits_tested", s_if.bits_tested, 10);
        sdrive(0, 0, 0);

        // Final accounting.
        check("status_queue_drained", exp_q.size(), 0);
        check("fwd_queue_drained", fwd_q.size(), 0);
        check("fwd_total", seen_fwd, exp_fwd_total);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
